eq_biquad_engine: RTL and testbench

- Time-multiplexed three-band (low/mid/high) biquad processor.
- Directly downstream of the SPI coefficient path: consumes the 15 signed coefficients driven by spi_top.
- Each band filters the same input sample in parallel; the three band outputs are summed and saturated.
- Pulses output_ready once per finished sample. That pulse is the only window in which the coefficient controller may swap coefficients.

---
 rtl/eq_pkg.sv | 35 +++
 rtl/biquad_mac.sv | 39 +++
 rtl/eq_biquad_engine.sv | 198 +++++++++++++++++++
 tb/tb_eq_biquad_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared widths, FSM state encoding, band indices and the saturation helper
// for the three-band biquad engine.
package eq_pkg;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 14;
    localparam int ACC_W     = 40;
    localparam int NUM_TAPS  = 5;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WB,
        SUM
    } state_t;

    localparam logic [1:0] LOW  = 2'd0;
    localparam logic [1:0] MID  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = ACC_W'(2 ** (DATA_W - 1) - 1);
        min_v = -max_v - ACC_W'(1);
        if (v > max_v)
            sat_data = max_v[DATA_W-1:0];
        else if (v < min_v)
            sat_data = min_v[DATA_W-1:0];
        else
            sat_data = v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// Shared multiply-accumulate datapath: one signed product per cycle, added or
// subtracted, with a Q2.14 round-half-up and saturate view of the accumulator.
module biquad_mac
    import eq_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     sub,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] operand,
    output logic signed [DATA_W-1:0] result
);

    localparam int PROD_W = COEF_W + DATA_W;
    localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(2 ** (COEF_FRAC - 1));

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  rounded;

    assign prod     = coef * operand;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            acc_reg <= '0;
        else if (clr)
            acc_reg <= '0;
        else if (en)
            acc_reg <= sub ? (acc_reg - prod_ext) : (acc_reg + prod_ext);
    end

    assign rounded = (acc_reg + HALF_LSB) >>> COEF_FRAC;
    assign result  = sat_data(rounded);

endmodule

// File: rtl/eq_biquad_engine.sv
// Three-band Direct Form I biquad engine sharing one MAC: 5 taps plus a
// write-back per band, then a saturated band sum, 20 cycles per sample.
module eq_biquad_engine
    import eq_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic signed [COEF_W-1:0] low_b0,
    input  logic signed [COEF_W-1:0] low_b1,
    input  logic signed [COEF_W-1:0] low_b2,
    input  logic signed [COEF_W-1:0] low_a1,
    input  logic signed [COEF_W-1:0] low_a2,
    input  logic signed [COEF_W-1:0] mid_b0,
    input  logic signed [COEF_W-1:0] mid_b1,
    input  logic signed [COEF_W-1:0] mid_b2,
    input  logic signed [COEF_W-1:0] mid_a1,
    input  logic signed [COEF_W-1:0] mid_a2,
    input  logic signed [COEF_W-1:0] high_b0,
    input  logic signed [COEF_W-1:0] high_b1,
    input  logic signed [COEF_W-1:0] high_b2,
    input  logic signed [COEF_W-1:0] high_a1,
    input  logic signed [COEF_W-1:0] high_a2,
    output logic signed [DATA_W-1:0] audio_out,
    output logic                     output_ready,
    output logic                     busy,
    output logic                     overrun
);

    state_t state_reg, state_next;
    logic [2:0] tap_reg;
    logic [1:0] band_reg;
    logic signed [DATA_W-1:0] x_reg, x1_reg, x2_reg;
    logic signed [DATA_W-1:0] audio_out_reg;
    logic output_ready_reg, overrun_reg;
    logic accept, mac_en, mac_clr, wb_en, sum_en;

    logic [2:0][DATA_W-1:0] y1_hist, y2_hist;
    logic signed [COEF_W-1:0] coef_band [NUM_TAPS];
    logic signed [DATA_W-1:0] y1_sel, y2_sel;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [DATA_W-1:0] operand_sel;
    logic signed [DATA_W-1:0] band_result;
    logic signed [DATA_W-1:0] y_low, y_mid, y_high;
    logic signed [DATA_W+1:0] sum_wide;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        wb_en      = 1'b0;
        sum_en     = 1'b0;
        case (state_reg)
            IDLE: if (sample_valid) begin
                accept     = 1'b1;
                mac_clr    = 1'b1;
                state_next = MAC;
            end
            MAC: begin
                mac_en = 1'b1;
                if (tap_reg == 3'd4)
                    state_next = WB;
            end
            WB: begin
                wb_en      = 1'b1;
                mac_clr    = 1'b1;
                state_next = (band_reg == HIGH) ? SUM : MAC;
            end
            SUM: begin
                sum_en     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tap_reg          <= '0;
            band_reg         <= LOW;
            x_reg            <= '0;
            x1_reg           <= '0;
            x2_reg           <= '0;
            audio_out_reg    <= '0;
            output_ready_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            output_ready_reg <= sum_en;
            if (accept) begin
                x_reg    <= sample_in;
                tap_reg  <= '0;
                band_reg <= LOW;
            end
            if (mac_en)
                tap_reg <= tap_reg + 3'd1;
            if (wb_en) begin
                tap_reg <= '0;
                if (band_reg != HIGH)
                    band_reg <= band_reg + 2'd1;
            end
            if (sum_en) begin
                audio_out_reg <= sat_data({{(ACC_W - DATA_W - 2){sum_wide[DATA_W+1]}}, sum_wide});
                x1_reg        <= x_reg;
                x2_reg        <= x1_reg;
            end
            // Strobes during a sample in flight are dropped, only flagged.
            if (sample_valid && state_reg != IDLE)
                overrun_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_band
            logic signed [DATA_W-1:0] y1_reg, y2_reg;
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    y1_reg <= '0;
                    y2_reg <= '0;
                end else if (wb_en && band_reg == 2'(gi)) begin
                    y1_reg <= band_result;
                    y2_reg <= y1_reg;
                end
            end
            assign y1_hist[gi] = y1_reg;
            assign y2_hist[gi] = y2_reg;
        end
    endgenerate

    always_comb begin
        coef_band = '{default: '0};
        y1_sel    = '0;
        y2_sel    = '0;
        case (band_reg)
            LOW: begin
                coef_band = '{low_b0, low_b1, low_b2, low_a1, low_a2};
                y1_sel    = y1_hist[LOW];
                y2_sel    = y2_hist[LOW];
            end
            MID: begin
                coef_band = '{mid_b0, mid_b1, mid_b2, mid_a1, mid_a2};
                y1_sel    = y1_hist[MID];
                y2_sel    = y2_hist[MID];
            end
            HIGH: begin
                coef_band = '{high_b0, high_b1, high_b2, high_a1, high_a2};
                y1_sel    = y1_hist[HIGH];
                y2_sel    = y2_hist[HIGH];
            end
            default: ;
        endcase
    end

    always_comb begin
        coef_sel    = '0;
        operand_sel = '0;
        case (tap_reg)
            3'd0: begin coef_sel = coef_band[0]; operand_sel = x_reg;  end
            3'd1: begin coef_sel = coef_band[1]; operand_sel = x1_reg; end
            3'd2: begin coef_sel = coef_band[2]; operand_sel = x2_reg; end
            3'd3: begin coef_sel = coef_band[3]; operand_sel = y1_sel; end
            3'd4: begin coef_sel = coef_band[4]; operand_sel = y2_sel; end
            default: ;
        endcase
    end

    // Feedback taps (a1, a2) subtract: denominator is 1 + a1 z^-1 + a2 z^-2.
    biquad_mac u_mac (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr     (mac_clr),
        .en      (mac_en),
        .sub     (tap_reg >= 3'd3),
        .coef    (coef_sel),
        .operand (operand_sel),
        .result  (band_result)
    );

    assign y_low    = y1_hist[LOW];
    assign y_mid    = y1_hist[MID];
    assign y_high   = y1_hist[HIGH];
    assign sum_wide = (DATA_W + 2)'(y_low) + (DATA_W + 2)'(y_mid) + (DATA_W + 2)'(y_high);

    assign audio_out    = audio_out_reg;
    assign output_ready = output_ready_reg;
    assign busy         = (state_reg != IDLE);
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_eq_biquad_engine.sv
// Self-checking bench for eq_biquad_engine: directed filter scenarios plus
// randomized back-to-back samples compared against an arithmetic reference.
module tb_eq_biquad_engine;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] c [3][5];
    logic signed [15:0] audio_out;
    logic               output_ready;
    logic               busy;
    logic               overrun;

    int checks = 0;
    int errors = 0;

    longint mx1, mx2;
    longint my1 [3];
    longint my2 [3];

    always #5 clk_in = ~clk_in;

    eq_biquad_engine dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .low_b0       (c[0][0]),
        .low_b1       (c[0][1]),
        .low_b2       (c[0][2]),
        .low_a1       (c[0][3]),
        .low_a2       (c[0][4]),
        .mid_b0       (c[1][0]),
        .mid_b1       (c[1][1]),
        .mid_b2       (c[1][2]),
        .mid_a1       (c[1][3]),
        .mid_a2       (c[1][4]),
        .high_b0      (c[2][0]),
        .high_b1      (c[2][1]),
        .high_b2      (c[2][2]),
        .high_a1      (c[2][3]),
        .high_a2      (c[2][4]),
        .audio_out    (audio_out),
        .output_ready (output_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // y = b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2, Q2.14 rounded half up, per band.
    function automatic logic signed [15:0] model_step(input longint x);
        longint acc, yb, sum;
        longint cb [5];
        sum = 0;
        for (int b = 0; b < 3; b++) begin
            for (int t = 0; t < 5; t++) cb[t] = c[b][t];
            acc = cb[0] * x + cb[1] * mx1 + cb[2] * mx2 - cb[3] * my1[b] - cb[4] * my2[b];
            yb = sat16((acc + 8192) >>> 14);
            my2[b] = my1[b];
            my1[b] = yb;
            sum += yb;
        end
        mx2 = mx1;
        mx1 = x;
        return 16'(sat16(sum));
    endfunction

    task automatic model_clear();
        mx1 = 0;
        mx2 = 0;
        for (int b = 0; b < 3; b++) begin
            my1[b] = 0;
            my2[b] = 0;
        end
    endtask

    task automatic zero_coefs();
        for (int b = 0; b < 3; b++)
            for (int t = 0; t < 5; t++)
                c[b][t] = '0;
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        model_clear();
    endtask

    // Drives one sample and checks the 20-cycle timing; returns in the
    // output_ready cycle so a following call lands back-to-back.
    task automatic send_sample(input logic signed [15:0] s, input logic signed [15:0] exp,
                               input int extra_at, input string name);
        int early;
        int busy_bad;
        early = 0;
        busy_bad = 0;
        sample_in = s;
        sample_valid = 1'b1;
        @(posedge clk_in);
        #1;
        sample_valid = 1'b0;
        for (int k = 1; k < 20; k++) begin
            if (output_ready !== 1'b0) early++;
            if (busy !== 1'b1) busy_bad++;
            if (k == extra_at) begin
                sample_valid = 1'b1;
                sample_in = 16'($urandom);
            end else begin
                sample_valid = 1'b0;
            end
            @(posedge clk_in);
            #1;
        end
        sample_valid = 1'b0;
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL %s early_ready: got %0d cycles with output_ready, want 0", name, early);
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL %s busy_window: got %0d cycles busy low, want 0", name, busy_bad);
        end
        checks++;
        if (output_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_at_20: got %b, want 1", name, output_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_20: got %b, want 0", name, busy);
        end
        checks++;
        if (audio_out !== exp) begin
            errors++;
            $display("FAIL %s audio_out: got %0d, want %0d", name, audio_out, exp);
        end
        $display("sample %s: in=%0d out=%0d expected=%0d", name, s, audio_out, exp);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (audio_out !== 16'sd0) begin errors++; $display("FAIL reset_audio: got %0d, want 0", audio_out); end
        checks++;
        if (output_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, want 0", output_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, want 0", overrun); end
    endtask

    task automatic test_passthrough();
        do_reset();
        zero_coefs();
        c[0][0] = 16'sh4000;
        send_sample(16'sd1000, 16'sd1000, 0, "passthrough");
        @(posedge clk_in);
        #1;
        checks++;
        if (output_ready !== 1'b0) begin errors++; $display("FAIL pass_ready_t21: got %b, want 0", output_ready); end
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (audio_out !== 16'sd1000) begin errors++; $display("FAIL pass_hold: got %0d, want 1000", audio_out); end
    endtask

    task automatic test_saturation();
        do_reset();
        zero_coefs();
        for (int b = 0; b < 3; b++) c[b][0] = 16'sh4000;
        send_sample(16'sd30000, 16'sd32767, 0, "sat_pos");
        send_sample(-16'sd30000, -16'sd32768, 0, "sat_neg");
    endtask

    task automatic test_recursion();
        do_reset();
        zero_coefs();
        c[0][0] = 16'sh4000;
        c[0][3] = 16'shE000;
        send_sample(16'sd16384, 16'sd16384, 0, "rec0");
        send_sample(16'sd0, 16'sd8192, 0, "rec1");
        send_sample(16'sd0, 16'sd4096, 0, "rec2");
    endtask

    task automatic test_feedforward();
        do_reset();
        zero_coefs();
        c[1][2] = 16'sh4000;
        send_sample(16'sd500, 16'sd0, 0, "ff0");
        send_sample(16'sd0, 16'sd0, 0, "ff1");
        send_sample(16'sd0, 16'sd500, 0, "ff2");
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] s, e;
        do_reset();
        for (int set = 0; set < 3; set++) begin
            // Coefficients change only in the output_ready cycle (or idle).
            for (int b = 0; b < 3; b++)
                for (int t = 0; t < 5; t++)
                    c[b][t] = 16'($urandom_range(0, 65535));
            for (int n = 0; n < 6; n++) begin
                s = 16'($urandom);
                e = model_step(s);
                send_sample(s, e, 0, $sformatf("rand_s%0d_n%0d", set, n));
            end
        end
    endtask

    task automatic test_overrun();
        logic signed [15:0] s, e;
        do_reset();
        for (int b = 0; b < 3; b++)
            for (int t = 0; t < 5; t++)
                c[b][t] = 16'($urandom_range(0, 65535));
        s = 16'($urandom);
        e = model_step(s);
        send_sample(s, e, 5, "overrun_hit");
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b, want 1", overrun); end
        s = 16'($urandom);
        e = model_step(s);
        send_sample(s, e, 0, "overrun_next");
        repeat (4) @(posedge clk_in);
        #1;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b, want 1", overrun); end
    endtask

    task automatic test_reset_mid_sample();
        int fired;
        do_reset();
        zero_coefs();
        c[0][0] = 16'sh4000;
        c[0][3] = 16'shE000;
        send_sample(16'sd16384, 16'sd16384, 0, "pre_reset");
        sample_in = 16'sd12345;
        sample_valid = 1'b1;
        @(posedge clk_in);
        #1;
        sample_valid = 1'b0;
        repeat (9) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        checks++;
        if (audio_out !== 16'sd0) begin errors++; $display("FAIL midrst_audio: got %0d, want 0", audio_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, want 0", busy); end
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        fired = 0;
        for (int k = 0; k < 25; k++) begin
            if (output_ready !== 1'b0) fired++;
            @(posedge clk_in);
            #1;
        end
        checks++;
        if (fired !== 0) begin errors++; $display("FAIL midrst_ready: got %0d pulses, want 0", fired); end
        checks++;
        if (audio_out !== 16'sd0) begin errors++; $display("FAIL midrst_audio_after: got %0d, want 0", audio_out); end
        send_sample(16'sd16384, 16'sd16384, 0, "post_rst0");
        send_sample(16'sd0, 16'sd8192, 0, "post_rst1");
        send_sample(16'sd0, 16'sd4096, 0, "post_rst2");
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b, want 0", overrun); end
    endtask

    initial begin
        zero_coefs();
        model_clear();
        test_reset();
        test_passthrough();
        test_saturation();
        test_recursion();
        test_feedforward();
        test_back_to_back();
        test_overrun();
        test_reset_mid_sample();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
